// File: rtl/riscv_structures.sv
// Shared execute-stage types: forwarding selects, M-extension ops, MDU FSM
// states, ALU and branch-compare encodings.
package riscv_structures;

   typedef enum logic [1:0] {REG = 2'd0, MEM = 2'd1, WB = 2'd2} hu_src_e;

   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } md_op_e;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_e;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [2:0] BR_EQ  = 3'd0;
   localparam logic [2:0] BR_NE  = 3'd1;
   localparam logic [2:0] BR_LT  = 3'd4;
   localparam logic [2:0] BR_GE  = 3'd5;
   localparam logic [2:0] BR_LTU = 3'd6;
   localparam logic [2:0] BR_GEU = 3'd7;

endpackage

// File: rtl/alu.sv
// Integer ALU shared by the execute stage.
module alu
   import riscv_structures::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] y
);
   localparam int SH = $clog2(XLEN);
   logic [SH-1:0] shamt;
   assign shamt = b[SH-1:0];

   // combinational operation select
   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:   y = a + b;
         ALU_SUB:   y = a - b;
         ALU_SLL:   y = a << shamt;
         ALU_SLT:   y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU:  y = {{(XLEN-1){1'b0}}, a < b};
         ALU_XOR:   y = a ^ b;
         ALU_SRL:   y = a >> shamt;
         ALU_SRA:   y = $signed(a) >>> shamt;
         ALU_OR:    y = a | b;
         ALU_AND:   y = a & b;
         ALU_PASSB: y = b;
         default:   y = '0;
      endcase
   end
endmodule

// File: rtl/compare.sv
// Branch condition evaluation on funct3.
module compare
   import riscv_structures::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      funct3,
   output logic            taken
);
   // branch truth table
   always_comb begin
      taken = 1'b0;
      case (funct3)
         BR_EQ:   taken = (a == b);
         BR_NE:   taken = (a != b);
         BR_LT:   taken = ($signed(a) < $signed(b));
         BR_GE:   taken = ($signed(a) >= $signed(b));
         BR_LTU:  taken = (a < b);
         BR_GEU:  taken = (a >= b);
         default: taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes,
// signs and divide-by-zero fixed up on the way out.
module mdu_iter
   import riscv_structures::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  md_op_e          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN + 1);

   // acc: {high product | remainder, low product | quotient}
   logic [2*XLEN-1:0] acc, prod_fix;
   logic [XLEN-1:0]   opnd, a_q, a_mag, b_mag, quo, rem;
   logic [XLEN:0]     add_sum, sub_try;
   logic [CW-1:0]     cnt;
   md_op_e            op_q;
   logic              a_sgn, b_sgn, neg_q, neg_r, div0, run;

   // operand signedness and magnitudes
   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (op)
         MD_MULH, MD_DIV, MD_REM: begin
            a_sgn = a[XLEN-1];
            b_sgn = b[XLEN-1];
         end
         MD_MULHSU: a_sgn = a[XLEN-1];
         default: ;
      endcase
      a_mag = a_sgn ? -a : a;
      b_mag = b_sgn ? -b : b;
   end

   assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign sub_try = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};

   // shift-add multiply / restoring divide, down-counter terminates the run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         opnd  <= '0;
         a_q   <= '0;
         op_q  <= MD_MUL;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div0  <= 1'b0;
         run   <= 1'b0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            acc   <= {{XLEN{1'b0}}, a_mag};
            opnd  <= b_mag;
            a_q   <= a;
            op_q  <= op;
            neg_q <= a_sgn ^ b_sgn;
            neg_r <= a_sgn;
            div0  <= (b == '0);
            run   <= 1'b1;
            cnt   <= CW'(XLEN);
         end else if (run) begin
            if (op_q[2]) begin
               if (!sub_try[XLEN]) acc <= {sub_try[XLEN-1:0], acc[XLEN-2:0], 1'b1};
               else                acc <= {acc[2*XLEN-2:0], 1'b0};
            end else begin
               acc <= {add_sum, acc[XLEN-1:1]};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   // sign restore and special cases
   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      result   = '0;
      case (op_q)
         MD_MUL:                       result = prod_fix[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              result = div0 ? '1 : quo;
         default:                      result = div0 ? a_q : rem;
      endcase
   end
endmodule

// File: rtl/execute_mdu.sv
// Execute stage: operand forwarding, ALU, branch compare and an optional
// iterative M-extension unit sharing one output register toward MEM.
//
// state | meaning
// IDLE  | accepting instructions, ALU results registered in one cycle
// MUL   | multiply iterating (plus one cycle waiting on done)
// DIV   | divide iterating (plus one cycle waiting on done)
// DONE  | M-op result loaded into the output register
module execute_mdu
   import riscv_structures::*;
#(
   parameter int XLEN  = 32,
   parameter bit MD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  hu_src_e         rs1s,
   input  hu_src_e         rs2s,
   input  logic [XLEN-1:0] bp_mem,
   input  logic [XLEN-1:0] bp_wb,
   input  logic [XLEN-1:0] pc_value,
   input  logic [XLEN-1:0] immediate_sext,
   input  logic            use_pc,
   input  logic            use_imm,
   input  logic [3:0]      alu_op,
   input  logic            md_en,
   input  logic [2:0]      md_op,
   input  logic            is_branch,
   input  logic [2:0]      funct3,
   input  logic [4:0]      rd,
   input  logic            reg_write,
   input  logic            mem_read,
   input  logic            mem_write,
   output logic            out_valid,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] write_data,
   output logic [4:0]      rd_o,
   output logic            reg_write_o,
   output logic            mem_read_o,
   output logic            mem_write_o,
   output logic            pc_reset,
   output logic            busy
);
   mdu_state_e      state, state_nx;
   logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, alu_y, md_result, wd_q;
   logic [4:0]      rd_q;
   logic            rw_q, mr_q, mw_q, taken, xfer, md_go, md_done;

   // forwarding muxes
   always_comb begin
      rs1_val = rs1_data;
      rs2_val = rs2_data;
      case (rs1s)
         MEM:     rs1_val = bp_mem;
         WB:      rs1_val = bp_wb;
         default: rs1_val = rs1_data;
      endcase
      case (rs2s)
         MEM:     rs2_val = bp_mem;
         WB:      rs2_val = bp_wb;
         default: rs2_val = rs2_data;
      endcase
   end

   assign op_a     = use_pc  ? pc_value       : rs1_val;
   assign op_b     = use_imm ? immediate_sext : rs2_val;
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign xfer     = in_valid & in_ready;
   assign md_go    = xfer & MD_EN & md_en;

   alu #(.XLEN(XLEN)) u_alu (.a(op_a), .b(op_b), .op(alu_op), .y(alu_y));

   compare #(.XLEN(XLEN)) u_cmp (.a(rs1_val), .b(rs2_val), .funct3(funct3), .taken(taken));

   mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk(clk), .rst(rst), .start(md_go), .op(md_op_e'(md_op)),
      .a(rs1_val), .b(rs2_val), .done(md_done), .result(md_result)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // FSM next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (md_go) state_nx = md_op[2] ? DIV : MUL;
         MUL, DIV: if (md_done) state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // destination and control held across the M-op
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
         rw_q <= 1'b0;
         mr_q <= 1'b0;
         mw_q <= 1'b0;
         wd_q <= '0;
      end else if (md_go) begin
         rd_q <= rd;
         rw_q <= reg_write;
         mr_q <= mem_read;
         mw_q <= mem_write;
         wd_q <= rs2_val;
      end
   end

   // output register: bubble by default, ALU result on transfer, MDU result in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         alu_result  <= '0;
         write_data  <= '0;
         rd_o        <= '0;
         reg_write_o <= 1'b0;
         mem_read_o  <= 1'b0;
         mem_write_o <= 1'b0;
         pc_reset    <= 1'b0;
      end else begin
         out_valid   <= 1'b0;
         reg_write_o <= 1'b0;
         mem_read_o  <= 1'b0;
         mem_write_o <= 1'b0;
         pc_reset    <= 1'b0;
         if (state == DONE) begin
            out_valid   <= 1'b1;
            alu_result  <= md_result;
            write_data  <= wd_q;
            rd_o        <= rd_q;
            reg_write_o <= rw_q;
            mem_read_o  <= mr_q;
            mem_write_o <= mw_q;
         end else if (xfer && !md_go) begin
            out_valid   <= 1'b1;
            alu_result  <= alu_y;
            write_data  <= rs2_val;
            rd_o        <= rd;
            reg_write_o <= reg_write;
            mem_read_o  <= mem_read;
            mem_write_o <= mem_write;
            pc_reset    <= is_branch & taken;
         end
      end
   end
endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu: XLEN=32 instance for most scenarios and an
// XLEN=64 instance for the wide multiply.
module tb_execute_mdu;
   import riscv_structures::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, use_pc, use_imm, md_en, is_branch;
   logic [31:0] rs1_data, rs2_data, bp_mem, bp_wb, pc_value, immediate_sext;
   logic [31:0] alu_result, write_data;
   hu_src_e     rs1s, rs2s;
   logic [3:0]  alu_op;
   logic [2:0]  md_op, funct3;
   logic [4:0]  rd, rd_o;
   logic        reg_write, mem_read, mem_write;
   logic        out_valid, reg_write_o, mem_read_o, mem_write_o, pc_reset, busy;

   logic        w_in_valid, w_in_ready, w_out_valid, w_reg_write_o, w_mem_read_o, w_mem_write_o, w_pc_reset, w_busy;
   logic [63:0] w_rs1_data, w_rs2_data, w_zero, w_alu_result, w_write_data;
   logic [4:0]  w_rd_o;

   int vectors = 0;
   int errors  = 0;

   execute_mdu #(.XLEN(32), .MD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1s(rs1s), .rs2s(rs2s),
      .bp_mem(bp_mem), .bp_wb(bp_wb), .pc_value(pc_value), .immediate_sext(immediate_sext),
      .use_pc(use_pc), .use_imm(use_imm), .alu_op(alu_op), .md_en(md_en), .md_op(md_op),
      .is_branch(is_branch), .funct3(funct3), .rd(rd), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .out_valid(out_valid),
      .alu_result(alu_result), .write_data(write_data), .rd_o(rd_o),
      .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .pc_reset(pc_reset), .busy(busy)
   );

   execute_mdu #(.XLEN(64), .MD_EN(1'b1)) dut64 (
      .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .rs1_data(w_rs1_data), .rs2_data(w_rs2_data), .rs1s(rs1s), .rs2s(rs2s),
      .bp_mem(w_zero), .bp_wb(w_zero), .pc_value(w_zero), .immediate_sext(w_zero),
      .use_pc(use_pc), .use_imm(use_imm), .alu_op(alu_op), .md_en(md_en), .md_op(md_op),
      .is_branch(is_branch), .funct3(funct3), .rd(rd), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .out_valid(w_out_valid),
      .alu_result(w_alu_result), .write_data(w_write_data), .rd_o(w_rd_o),
      .reg_write_o(w_reg_write_o), .mem_read_o(w_mem_read_o), .mem_write_o(w_mem_write_o),
      .pc_reset(w_pc_reset), .busy(w_busy)
   );

   task automatic clear_inputs();
      in_valid = 1'b0; use_pc = 1'b0; use_imm = 1'b0; md_en = 1'b0; is_branch = 1'b0;
      rs1_data = '0; rs2_data = '0; bp_mem = '0; bp_wb = '0; pc_value = '0; immediate_sext = '0;
      rs1s = REG; rs2s = REG; alu_op = ALU_ADD; md_op = 3'd0; funct3 = 3'd0;
      rd = 5'd0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // one-cycle transfer; outputs of that edge are visible on return
   task automatic pulse_xfer();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // launches an M-op with rs1 forwarded from MEM, then disturbs the bypass
   task automatic run_mop(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
      clear_inputs();
      md_en = 1'b1; md_op = op; rs1s = MEM; bp_mem = a; rs1_data = 32'h5A5A5A5A;
      rs2_data = b; rd = 5'd3; reg_write = 1'b1;
      pulse_xfer();
      md_en = 1'b0; bp_mem = 32'hDEADBEEF; rs2_data = 32'h12345678;
      lat = 0; res = '0;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            lat = c; res = alu_result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      vectors++; if (alu_result !== 32'h0 || write_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h/%h want 0/0", alu_result, write_data); end
      vectors++; if (pc_reset !== 1'b0 || rd_o !== 5'd0 || reg_write_o !== 1'b0) begin errors++; $display("FAIL rst_ctrl: got %b/%h/%b want 0/0/0", pc_reset, rd_o, reg_write_o); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b/%b want 1/0", in_ready, busy); end
   endtask

   task automatic test_alu_forward();
      clear_inputs();
      alu_op = ALU_ADD; rs1s = MEM; bp_mem = 32'd5; rs1_data = 32'd100; rs2_data = 32'd7;
      rd = 5'd9; reg_write = 1'b1;
      pulse_xfer();
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_fwd_valid: got %b want 1", out_valid); end
      vectors++; if (alu_result !== 32'd12) begin errors++; $display("FAIL add_fwd_result: got %h want %h", alu_result, 32'd12); end
      vectors++; if (write_data !== 32'd7 || rd_o !== 5'd9 || reg_write_o !== 1'b1) begin errors++; $display("FAIL add_fwd_ctrl: got %h/%h/%b want 7/9/1", write_data, rd_o, reg_write_o); end
   endtask

   task automatic test_alu_mux();
      clear_inputs();
      alu_op = ALU_ADD; use_pc = 1'b1; pc_value = 32'h1000; use_imm = 1'b1; immediate_sext = 32'h20; rs1_data = 32'h7;
      pulse_xfer();
      vectors++; if (alu_result !== 32'h1020) begin errors++; $display("FAIL pc_imm_add: got %h want %h", alu_result, 32'h1020); end
      clear_inputs();
      alu_op = ALU_SUB; rs1_data = 32'd10; rs2s = WB; bp_wb = 32'd15; rs2_data = 32'd1;
      pulse_xfer();
      vectors++; if (alu_result !== 32'hFFFFFFFB) begin errors++; $display("FAIL sub_fwd_wb: got %h want %h", alu_result, 32'hFFFFFFFB); end
      vectors++; if (write_data !== 32'd15) begin errors++; $display("FAIL store_data_fwd: got %h want %h", write_data, 32'd15); end
      clear_inputs();
      alu_op = ALU_SRA; rs1_data = 32'h80000000; use_imm = 1'b1; immediate_sext = 32'd4;
      pulse_xfer();
      vectors++; if (alu_result !== 32'hF8000000) begin errors++; $display("FAIL sra_imm: got %h want %h", alu_result, 32'hF8000000); end
   endtask

   task automatic test_branch();
      clear_inputs();
      is_branch = 1'b1; funct3 = BR_EQ; rs1s = WB; bp_wb = 32'd3; rs1_data = 32'd9; rs2_data = 32'd3;
      pulse_xfer();
      vectors++; if (pc_reset !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", pc_reset); end
      clear_inputs();
      @(posedge clk); #1;
      vectors++; if (pc_reset !== 1'b0) begin errors++; $display("FAIL beq_one_cycle: got %b want 0", pc_reset); end
      is_branch = 1'b1; funct3 = BR_LT; rs1_data = 32'hFFFFFFFF; rs2s = MEM; bp_mem = 32'd1; rs2_data = 32'h80000000;
      pulse_xfer();
      vectors++; if (pc_reset !== 1'b1) begin errors++; $display("FAIL blt_fwd: got %b want 1", pc_reset); end
      clear_inputs();
      is_branch = 1'b1; funct3 = BR_NE; rs1_data = 32'd5; rs2_data = 32'd5;
      pulse_xfer();
      vectors++; if (pc_reset !== 1'b0) begin errors++; $display("FAIL bne_not_taken: got %b want 0", pc_reset); end
      clear_inputs();
      is_branch = 1'b0; funct3 = BR_EQ; rs1_data = 32'd4; rs2_data = 32'd4;
      pulse_xfer();
      vectors++; if (pc_reset !== 1'b0) begin errors++; $display("FAIL non_branch_eq: got %b want 0", pc_reset); end
   endtask

   task automatic test_idle();
      clear_inputs();
      mem_write = 1'b1; rs1_data = 32'h100; rs2_data = 32'hABCD;
      pulse_xfer();
      vectors++; if (mem_write_o !== 1'b1 || write_data !== 32'hABCD) begin errors++; $display("FAIL store_pass: got %b/%h want 1/abcd", mem_write_o, write_data); end
      reg_write = 1'b1; mem_write = 1'b1; mem_read = 1'b1;
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0 || reg_write_o !== 1'b0 || mem_write_o !== 1'b0 || mem_read_o !== 1'b0)
         begin errors++; $display("FAIL idle_bubble: got v%b rw%b mw%b mr%b want all 0", out_valid, reg_write_o, mem_write_o, mem_read_o); end
   endtask

   task automatic test_mulhu();
      int lat = 0;
      int bad_ready = 0;
      int bad_bubble = 0;
      clear_inputs();
      md_en = 1'b1; md_op = 3'd3; rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF; rd = 5'd7; reg_write = 1'b1;
      pulse_xfer();
      clear_inputs();
      reg_write = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
         if (out_valid !== 1'b0 || reg_write_o !== 1'b0) bad_bubble++;
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
      vectors++; if (lat !== 34) begin errors++; $display("FAIL mulhu_latency: got %0d want 34", lat); end
      vectors++; if (alu_result !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_result: got %h want %h", alu_result, 32'hFFFFFFFE); end
      vectors++; if (rd_o !== 5'd7 || reg_write_o !== 1'b1) begin errors++; $display("FAIL mulhu_ctrl: got %h/%b want 7/1", rd_o, reg_write_o); end
      vectors++; if (bad_ready !== 0) begin errors++; $display("FAIL mulhu_in_ready_low: got %0d bad cycles want 0", bad_ready); end
      vectors++; if (bad_bubble !== 0) begin errors++; $display("FAIL mulhu_bubble: got %0d bad cycles want 0", bad_bubble); end
      clear_inputs();
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mulhu_after: got v%b r%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_mdu_ops();
      logic [2:0]  ops [11] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6};
      logic [31:0] as  [11] = '{32'h80000000, 32'h80000000, 32'd9, 32'd9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'd7, 32'hFFFFFFF9};
      logic [31:0] bs  [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2,
                               32'd2, 32'hFFFFFFFF, 32'h00010001, 32'd0, 32'd0};
      logic [31:0] exp [11] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFF9};
      logic [31:0] res;
      int lat;
      for (int i = 0; i < 11; i++) begin
         run_mop(ops[i], as[i], bs[i], res, lat);
         vectors++; if (lat !== 34) begin errors++; $display("FAIL mop%0d_latency: got %0d want 34", i, lat); end
         vectors++; if (res !== exp[i]) begin errors++; $display("FAIL mop%0d_op%0d_result: got %h want %h", i, ops[i], res, exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int stray = 0;
      clear_inputs();
      md_en = 1'b1; md_op = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd11; reg_write = 1'b1;
      pulse_xfer();
      clear_inputs();
      repeat (10) @(posedge clk);
      #1;
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_before_rst: got %b want 1", busy); end
      rst = 1'b1; #1;
      vectors++; if (out_valid !== 1'b0 || alu_result !== 32'h0 || rd_o !== 5'd0 || write_data !== 32'h0)
         begin errors++; $display("FAIL rst_mid_outputs: got v%b %h %h %h want 0", out_valid, alu_result, rd_o, write_data); end
      vectors++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got b%b r%b want 0/1", busy, in_ready); end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) stray++;
      end
      vectors++; if (stray !== 0) begin errors++; $display("FAIL rst_mid_no_result: got %0d valid cycles want 0", stray); end
      alu_op = ALU_ADD; rs1_data = 32'd20; rs2_data = 32'd22; rd = 5'd4; reg_write = 1'b1;
      pulse_xfer();
      vectors++; if (out_valid !== 1'b1 || alu_result !== 32'd42) begin errors++; $display("FAIL add_after_rst: got v%b %h want 1/%h", out_valid, alu_result, 32'd42); end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      in_valid = 1'b1; alu_op = ALU_XOR; rs1_data = 32'hF0F0F0F0; rs2_data = 32'hFF00FF00; rd = 5'd1;
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || alu_result !== 32'h0FF00FF0) begin errors++; $display("FAIL b2b_first: got v%b %h want 1/0ff00ff0", out_valid, alu_result); end
      alu_op = ALU_AND; rs1s = MEM; bp_mem = 32'h0000FFFF; rs2_data = 32'h12345678; rd = 5'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1 || alu_result !== 32'h00005678 || rd_o !== 5'd2)
         begin errors++; $display("FAIL b2b_second: got v%b %h rd%h want 1/00005678/2", out_valid, alu_result, rd_o); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_mul64();
      int lat = 0;
      clear_inputs();
      md_en = 1'b1; md_op = 3'd0; rd = 5'd6; reg_write = 1'b1;
      w_rs1_data = 64'hFFFFFFFFFFFFFFFD; w_rs2_data = 64'd5; w_in_valid = 1'b1;
      @(posedge clk); #1;
      w_in_valid = 1'b0; md_en = 1'b0; w_rs1_data = '0; w_rs2_data = '0;
      for (int c = 1; c <= 120; c++) begin
         @(posedge clk); #1;
         if (w_out_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
      vectors++; if (lat !== 66) begin errors++; $display("FAIL mul64_latency: got %0d want 66", lat); end
      vectors++; if (w_alu_result !== 64'hFFFFFFFFFFFFFFF1) begin errors++; $display("FAIL mul64_result: got %h want %h", w_alu_result, 64'hFFFFFFFFFFFFFFF1); end
   endtask

   initial begin
      clear_inputs();
      w_in_valid = 1'b0; w_rs1_data = '0; w_rs2_data = '0; w_zero = '0;
      test_reset();
      test_alu_forward();
      test_alu_mux();
      test_branch();
      test_idle();
      test_mulhu();
      test_mdu_ops();
      test_reset_mid();
      test_back_to_back();
      test_mul64();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/execute_mdu.md
EXECUTE_MDU -- requirements
Module: execute_mdu

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter MD_EN, default 1, when 0 the multiply/divide unit is absent and md_en is ignored.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1 / in_ready  out  1: decode-to-execute handshake; a transfer occurs when both are high on a rising edge.
REQ-006 rs1_data, rs2_data  in  XLEN: register-file operands.
REQ-007 rs1s, rs2s  in  hu_src_e: forwarding select, with values REG, MEM and WB.
REQ-008 bp_mem, bp_wb  in  XLEN: bypass values from the MEM and WB stages.
REQ-009 pc_value, immediate_sext  in  XLEN; use_pc, use_imm  in  1: ALU operand-A and operand-B muxing.
REQ-010 alu_op  in  4: ALU operation, same encoding as the existing ALU.
REQ-011 md_en  in  1 / md_op  in  3: RV M-extension op, encoded as funct3 (MUL..REMU).
REQ-012 is_branch  in  1 / funct3  in  3: branch compare condition.
REQ-013 rd  in  5; reg_write, mem_read, mem_write  in  1: control signals passed through to MEM.
REQ-014 out_valid  out  1: the output register holds a real instruction this cycle.
REQ-015 alu_result, write_data  out  XLEN; rd_o  out  5; reg_write_o, mem_read_o, mem_write_o  out  1.
REQ-016 pc_reset  out  1: registered branch-taken pulse.
REQ-017 busy  out  1: high while an M-op iterates; hazard unit uses it to stall fetch and decode.

Function
REQ-018 Operand selection: rs1_val/rs2_val = bp_mem if MEM, bp_wb if WB, else register data; ALU A = pc_value if use_pc else rs1_val; ALU B = immediate_sext if use_imm else rs2_val.
REQ-019 Non-M instructions: results are registered with 1-cycle latency; out_valid=1 the cycle after the transfer; write_data = rs2_val.
REQ-020 Branch compare: uses forwarded rs1_val/rs2_val, not raw register data.
REQ-021 pc_reset: asserted for exactly one cycle after a transfer with is_branch=1 and a true condition; otherwise 0.
REQ-022 FSM states: IDLE, MUL, DIV, DONE.
REQ-023 IDLE: a transfer with md_en=1 (MD_EN=1) latches the operands, rd and control, then goes to MUL (md_op 0-3) or DIV (md_op 4-7).
REQ-024 MUL and DIV: iterate exactly XLEN cycles, one bit per cycle (shift-add, restoring divide), then go to DONE.
REQ-025 DONE: drives the result with out_valid=1 for one cycle, then returns to IDLE.
REQ-026 in_ready = 1 only in IDLE; busy = 1 in MUL, DIV and DONE.
REQ-027 M-op latency: XLEN+2 cycles from transfer to out_valid.
REQ-028 While busy: out_valid=0 and reg_write_o=mem_write_o=mem_read_o=0 (bubble).
REQ-029 Forwarded values are sampled only at the transfer edge; later bypass changes are ignored.
REQ-030 MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-031 Divide by zero: quotient = all ones, remainder = dividend; signed and unsigned alike.
REQ-032 Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
REQ-033 Division signs: the quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-034 in_valid=0 in IDLE: out_valid=0 next cycle and all control outputs 0.

Reset
REQ-035 Assertion of rst immediately forces: FSM=IDLE, out_valid=0, pc_reset=0, all control outputs 0, alu_result=write_data=0, rd_o=0.
REQ-036 Reset mid-iteration aborts the operation; no result is ever emitted for it.
REQ-037 in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-038 hu_src_e, the M-op encodings and the FSM state enum live in the shared riscv_structures package.
REQ-039 The iterative multiply/divide datapath is one sub-module, mdu_iter, with start/done handshake; the existing alu and compare are reused unchanged.

Verification
REQ-040 ADD with rs1s=MEM, bp_mem=5, rs2_data=7 -> alu_result=12, out_valid=1 one cycle later.
REQ-041 BEQ with rs1s=WB, bp_wb=3, rs2_data=3 -> pc_reset=1 for one cycle only.
REQ-042 MULHU 0xFFFFFFFF×0xFFFFFFFF (XLEN=32) -> result 0xFFFFFFFE after 34 cycles; in_ready=0 throughout.
REQ-043 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-044 rst asserted at cycle 10 of a DIV -> outputs zeroed immediately; no out_valid afterward; next ADD completes normally.
REQ-045 XLEN=64 build: MUL -3×5 -> 0xFFFFFFFFFFFFFFF1 after 66 cycles.
